// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC requests, in-order responses tagged with their PC,
// a DEPTH-entry instruction FIFO toward decode, and redirect/restart with stale-response discard.
module fetch_unit #(
    parameter int                XLEN         = 32,
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned       PC_STEP      = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_mem_req_valid,
    output logic [ADDR_W-1:0] inst_mem_req_addr,
    input  logic              inst_mem_req_ack,
    input  logic              inst_mem_rsp_valid,
    input  logic [XLEN-1:0]   inst_mem_rsp_data,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
    logic [XLEN-1:0]   fifo_data_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
    logic [ADDR_W-1:0] pq_q        [DEPTH];
    logic              flush_s, acc_s, drop_s, wr_s, pop_s;

    // Next-state computation: counters, pointers, PC and FSM, with flush taking priority
    always_comb begin
        flush_s     = reset_pc || redirect_valid;
        acc_s       = req_valid_q && inst_mem_req_ack;
        drop_s      = inst_mem_rsp_valid && (disc_q != '0);
        wr_s        = inst_mem_rsp_valid && (disc_q == '0) && !flush_s;
        pop_s       = (cnt_q != '0) && instr_ready && !flush_s;
        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = out_q;
        disc_d      = disc_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        pq_rd_d     = pq_rd_q;
        pq_wr_d     = pq_wr_q;
        if (flush_s) begin
            if (reset_pc) begin
                pc_d = RESET_VECTOR;
            end else begin
                pc_d = redirect_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
            end
            // every in-flight request (including one accepted now) becomes stale; a response now retires one
            disc_d  = disc_q + out_q + CW'(acc_s) - CW'(inst_mem_rsp_valid);
            out_d   = '0;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            pq_rd_d = '0;
            pq_wr_d = '0;
            state_d = (disc_d != '0) ? S_FLUSH : S_FETCH;
        end else begin
            if (acc_s) begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end else begin
                pc_d = pc_q;
            end
            out_d   = out_q + CW'(acc_s) - CW'(wr_s);
            disc_d  = disc_q - CW'(drop_s);
            cnt_d   = cnt_q + CW'(wr_s) - CW'(pop_s);
            rd_d    = rd_q + PW'(pop_s);
            wr_d    = wr_q + PW'(wr_s);
            pq_rd_d = pq_rd_q + PW'(wr_s);
            pq_wr_d = pq_wr_q + PW'(acc_s);
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: state_d = S_FETCH;
                S_FLUSH: state_d = (disc_d == '0) ? S_FETCH : S_FLUSH;
                default: state_d = S_IDLE;
            endcase
        end
        req_valid_d = !flush_s && (state_d == S_FETCH) &&
                      (({1'b0, cnt_d} + {1'b0, out_d}) < {1'b0, DEPTH_C});
        busy_d      = (state_d == S_FLUSH) || (out_d != '0);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            disc_q      <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            pq_rd_q     <= '0;
            pq_wr_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            pq_rd_q     <= pq_rd_d;
            pq_wr_q     <= pq_wr_d;
        end
    end

    // Storage: PC tag queue written at accept, instruction FIFO written at response
    always_ff @(posedge clk) begin
        if (acc_s && !flush_s) begin
            pq_q[pq_wr_q] <= pc_q;
        end
        if (wr_s) begin
            fifo_data_q[wr_q] <= inst_mem_rsp_data;
            fifo_pc_q[wr_q]   <= pq_q[pq_rd_q];
        end
    end

    assign inst_mem_req_valid = req_valid_q;
    assign inst_mem_req_addr  = pc_q;
    assign instr_valid        = (cnt_q != '0);
    assign instr_data         = instr_valid ? fifo_data_q[rd_q] : '0;
    assign instr_pc           = instr_valid ? fifo_pc_q[rd_q] : '0;
    assign busy               = busy_q;

    fetch_unit_chk #(.CW(CW), .DEPTH_C(DEPTH_C)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .rsp_valid(inst_mem_rsp_valid),
        .cnt      (cnt_q),
        .out      (out_q),
        .disc     (disc_q)
    );
endmodule

// Protocol checks: credits never exceed DEPTH, and a kept response always has a request to match.
module fetch_unit_chk #(
    parameter int            CW      = 3,
    parameter logic [CW-1:0] DEPTH_C = '0
) (
    input logic          clk,
    input logic          reset,
    input logic          rsp_valid,
    input logic [CW-1:0] cnt,
    input logic [CW-1:0] out,
    input logic [CW-1:0] disc
);
    a_credit: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, cnt} + {1'b0, out}) <= {1'b0, DEPTH_C}));
    a_rsp_has_req: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && (disc == '0)) |-> (out != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable latency, PC/data scoreboard,
// directed sequences and a table of redirect/restart vectors.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1, reset_pc = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'd0;
    logic        inst_mem_req_valid, inst_mem_req_ack = 1'b0;
    logic [31:0] inst_mem_req_addr;
    logic        inst_mem_rsp_valid = 1'b0;
    logic [31:0] inst_mem_rsp_data = 32'd0;
    logic        instr_valid, instr_ready = 1'b0, busy;
    logic [31:0] instr_data, instr_pc;

    fetch_unit dut (
        .clk(clk), .reset(reset), .reset_pc(reset_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .inst_mem_req_valid(inst_mem_req_valid), .inst_mem_req_addr(inst_mem_req_addr),
        .inst_mem_req_ack(inst_mem_req_ack),
        .inst_mem_rsp_valid(inst_mem_rsp_valid), .inst_mem_rsp_data(inst_mem_rsp_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        ack_on;
        int          pre;
        logic        rpc;
        logic [31:0] target;
        logic [31:0] exp_first;
        logic        exp_busy;
    } vec_t;
    vec_t vecs [5];

    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, lat = 1, n_acc = 0, n_fire = 0;
    logic        ack_en = 1'b0, ready_en = 1'b0;
    logic        watch_first = 1'b0, chk_gap = 1'b0;
    logic [31:0] exp_req = 32'd0, first_exp = 32'd0;
    logic [31:0] exp_q [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill_exp(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 80; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; reset_pc = 1'b0; redirect_valid = 1'b0; inst_mem_req_ack = 1'b0;
        inst_mem_rsp_valid = 1'b0; inst_mem_rsp_data = 32'd0; instr_ready = 1'b0;
        pend_addr.delete(); pend_due.delete();
        @(negedge clk);
        chk("rst_req_valid", 32'(inst_mem_req_valid), 32'd0);
        chk("rst_req_addr", inst_mem_req_addr, 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        fill_exp(32'd0);
        exp_req = 32'd0; watch_first = 1'b0; chk_gap = 1'b0;
        cyc = 0; n_acc = 0; n_fire = 0;
    endtask

    task automatic tick(input logic redir, input logic rpc, input logic [31:0] raddr,
                        input logic [31:0] new_pc);
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        redirect_valid   = redir;
        reset_pc         = rpc;
        redirect_addr    = raddr;
        inst_mem_req_ack = ack_en;
        instr_ready      = ready_en && !redir && !rpc;
        if (chk_gap) begin
            chk("gap_req_valid", 32'(inst_mem_req_valid), 32'd0);
            chk("gap_instr_valid", 32'(instr_valid), 32'd0);
            chk_gap = 1'b0;
        end
        if (watch_first && inst_mem_req_valid) begin
            chk("first_req_addr", inst_mem_req_addr, first_exp);
            watch_first = 1'b0;
        end
        if (inst_mem_req_valid && inst_mem_req_ack) begin
            chk("req_addr", inst_mem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            n_acc++;
            pend_addr.push_back(inst_mem_req_addr);
            pend_due.push_back(cyc + lat);
        end
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            inst_mem_rsp_valid = 1'b1;
            inst_mem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            inst_mem_rsp_valid = 1'b0;
            inst_mem_rsp_data  = 32'd0;
        end
        if (instr_valid && instr_ready) begin
            n_fire++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_instr", instr_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e);
                chk("instr_data", instr_data, mem_word(e));
            end
        end
        if (redir || rpc) begin
            fill_exp(new_pc);
            exp_req = new_pc; first_exp = new_pc;
            watch_first = 1'b1; chk_gap = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        vecs[0] = '{4, 1'b1, 4, 1'b0, 32'h0000_0103, 32'h0000_0100, 1'b1};
        vecs[1] = '{1, 1'b1, 8, 1'b0, 32'h0000_2002, 32'h0000_2000, 1'b1};
        vecs[2] = '{2, 1'b1, 6, 1'b1, 32'h0000_5550, 32'h0000_0000, 1'b1};
        vecs[3] = '{1, 1'b0, 4, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[4] = '{1, 1'b1, 5, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 1'b1};

        // streaming: one instruction per cycle from the third cycle after release
        do_reset();
        lat = 1; ack_en = 1'b1; ready_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick(1'b0, 1'b0, 32'd0, 32'd0);
            chk("stream_instr_valid", 32'(instr_valid), (i >= 3) ? 32'd1 : 32'd0);
        end

        // decode stalled: credits stop issue after four requests
        do_reset();
        lat = 1; ack_en = 1'b1; ready_en = 1'b0;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_n_acc", 32'(n_acc), 32'd4);
        chk("stall_req_valid", 32'(inst_mem_req_valid), 32'd0);
        chk("stall_head_pc", instr_pc, 32'd0);
        ready_en = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_resume_fires", (n_fire >= 12) ? 32'd1 : 32'd0, 32'd1);

        // memory refuses: address held stable until accepted
        do_reset();
        lat = 1; ack_en = 1'b0; ready_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'd0, 32'd0);
            chk("hold_req_valid", 32'(inst_mem_req_valid), 32'd1);
            chk("hold_req_addr", inst_mem_req_addr, 32'd0);
        end
        ack_en = 1'b1;
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        chk("hold_next_addr", inst_mem_req_addr, 32'd4);

        // redirect / restart vectors, each starting with a mid-stream reset
        for (int v = 0; v < 5; v++) begin
            do_reset();
            lat = vecs[v].lat; ack_en = vecs[v].ack_on; ready_en = 1'b1;
            for (int i = 0; i < vecs[v].pre; i++) tick(1'b0, 1'b0, 32'd0, 32'd0);
            tick(!vecs[v].rpc, vecs[v].rpc, vecs[v].target, vecs[v].exp_first);
            ack_en = 1'b1;
            tick(1'b0, 1'b0, 32'd0, 32'd0);
            chk("redir_busy", 32'(busy), 32'(vecs[v].exp_busy));
            f0 = n_fire;
            for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 32'd0, 32'd0);
            chk("redir_first_seen", 32'(watch_first), 32'd0);
            chk("redir_delivered", ((n_fire - f0) >= 8) ? 32'd1 : 32'd0, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
